// File: rtl/number_uart_reporter_pkg.sv
// Shared constants, state types and the hex-to-ASCII helper for the number UART reporter.
package number_uart_reporter_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [2:0] {
    RPT_IDLE,
    RPT_LOAD,
    RPT_SEND,
    RPT_WAIT,
    RPT_FINISH
  } rpt_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_ZERO + {4'd0, nib};
    else             return ASCII_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/number_uart_reporter_uart_tx_byte.sv
// 8N1 byte serialiser. Handshake: byte_in is accepted on the cycle byte_valid and
// byte_ready are both high; byte_ready is high only while the serialiser is idle.
module uart_tx_byte
  import number_uart_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_t     state;
  tx_state_t     state_next;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          tx_next;
  logic          bit_end;

  assign bit_end    = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_ready = (state == TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_next    = STOP_BIT;
    case (state)
      TX_IDLE: begin
        if (byte_valid) state_next = TX_START;
      end
      TX_START: begin
        tx_next = START_BIT;
        if (bit_end) state_next = TX_DATA;
      end
      TX_DATA: begin
        tx_next = shift_q[bit_idx];
        if (bit_end && (bit_idx == 3'(DATA_BITS - 1))) state_next = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // tx is a registered copy of the bit the state machine is presenting, so the
  // line is glitch-free and every bit still lasts exactly CLKS_PER_BIT clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      tx      <= STOP_BIT;
    end else begin
      tx <= tx_next;
      if (state == TX_IDLE) begin
        bit_cnt <= '0;
        bit_idx <= '0;
        if (byte_valid) shift_q <= byte_in;
      end else if (bit_end) begin
        bit_cnt <= '0;
        if (state == TX_DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/number_uart_reporter.sv
// Sends a snapshot of number as uppercase hex text followed by CR LF over an 8N1 UART.
module number_uart_reporter
  import number_uart_reporter_pkg::*;
#(
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int BAUD_RATE                   = 1_000_000
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  input  logic                                                 send,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 usb_tx
);

  localparam int CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int NUM_W        = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
  localparam int NUM_CHARS    = NUMBER_OF_DIGITS + 2;
  localparam int IDX_W        = $clog2(NUM_CHARS + 1);

  rpt_state_t       state;
  rpt_state_t       state_next;
  logic [NUM_W-1:0] shadow;
  logic [NUM_W-1:0] shifted;
  logic [IDX_W-1:0] ch_idx;
  logic [7:0]       char_byte;
  logic             byte_valid;
  logic             byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RPT_IDLE;
    else        state <= state_next;
  end

  // LOAD offers the byte directly so the serialiser starts on the next edge;
  // SEND waits for it to leave idle, WAIT for it to come back.
  always_comb begin
    state_next = state;
    byte_valid = 1'b0;
    case (state)
      RPT_IDLE: begin
        if (send) state_next = RPT_LOAD;
      end
      RPT_LOAD: begin
        byte_valid = 1'b1;
        if (byte_ready) state_next = RPT_SEND;
      end
      RPT_SEND: begin
        if (!byte_ready) state_next = RPT_WAIT;
      end
      RPT_WAIT: begin
        if (byte_ready) begin
          state_next = (ch_idx == IDX_W'(NUM_CHARS)) ? RPT_FINISH : RPT_LOAD;
        end
      end
      RPT_FINISH: state_next = RPT_IDLE;
      default:    state_next = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      ch_idx <= '0;
    end else if ((state == RPT_IDLE) && send) begin
      shadow <= number;
      ch_idx <= '0;
    end else if (byte_valid && byte_ready) begin
      ch_idx <= ch_idx + IDX_W'(1);
    end
  end

  always_comb begin
    shifted   = shadow >> (NUMBER_OF_BITS_PER_DIGIT * (NUMBER_OF_DIGITS - 1 - int'(ch_idx)));
    char_byte = ASCII_LF;
    if (int'(ch_idx) < NUMBER_OF_DIGITS) char_byte = nibble_to_ascii(shifted[3:0]);
    else if (int'(ch_idx) == NUMBER_OF_DIGITS) char_byte = ASCII_CR;
  end

  assign busy = (state == RPT_LOAD) || (state == RPT_SEND) || (state == RPT_WAIT);
  assign done = (state == RPT_FINISH);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (char_byte),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx        (usb_tx)
  );

endmodule

// File: doc/number_uart_reporter.md
Name: number_uart_reporter

Overview:
Serial transmit side of the board's USB-UART link. It takes the 16-bit stopwatch/set number and sends it to the host over usb_tx as ASCII hex text. On a send request it captures the number, then serialises four hex characters (MSD first) followed by CR LF as 8N1 frames. It sits in the top level beside the display driver and takes over usb_tx, which the top level currently drives as a loopback of usb_rx.

Parameters:
NUMBER_OF_DIGITS, 4, hex digits transmitted per report
NUMBER_OF_BITS_PER_DIGIT, 4, bits per digit; fixed at 4 for hex
BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, clk frequency
BAUD_RATE, 1_000_000, UART bit rate; CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE (integer division, must be >= 4)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
number  input  NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT  value to report
send  input  1  single-cycle request to start a report; sampled on rising clk
busy  output  1  high while a report is in progress
done  output  1  one-cycle pulse when the final LF stop bit completes
usb_tx  output  1  UART line, idle high

Behaviour:
- Reset: while rst_n is low, usb_tx = 1, busy = 0 and done = 0, asynchronously. All counters clear and the FSM goes to IDLE.
- Report FSM states: IDLE, LOAD, SEND, WAIT, FINISH.
- IDLE -> LOAD: when send = 1 on a rising edge. On that same edge, number is snapshotted into a shadow register and busy goes to 1 (visible the cycle after send).
- LOAD: selects the next character and hands it to the serialiser. Character order:
  - digit[NUMBER_OF_DIGITS-1] down to digit[0]
  - then 0x0D, then 0x0A
- Hex encoding: nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46 (uppercase).
- SEND/WAIT: wait for the serialiser to accept the byte and then finish it. Then return to LOAD while characters remain, otherwise go to FINISH.
- FINISH: done = 1 for exactly one cycle and busy = 0 in that same cycle. Then go to IDLE.
- send while busy = 1 (including the FINISH cycle) is ignored; nothing is queued.
- Changes on number during a report have no effect; only the snapshot is sent.
- Frame format: start bit 0, then 8 data bits LSB first, then 1 stop bit 1. Each bit holds for exactly CLKS_PER_BIT clocks. No parity.
- Timing:
  - First start bit begins (usb_tx falls) exactly 2 cycles after the edge that samples send.
  - Idle gap between one stop bit's end and the next start bit is at most 2 clocks.
  - Total report time = 6*10*CLKS_PER_BIT + at most 12 clocks.
- Reset mid-frame: usb_tx returns high immediately and the partial character is abandoned. No done pulse. A send after rst_n deasserts starts a fresh full report.
- Serialiser handshake (internal): byte_valid/byte_ready. The byte is accepted on the cycle both are high. byte_ready is high only in its IDLE state.

Decomposition:
- Shared package:
  - ASCII_CR = 8'h0D, ASCII_LF = 8'h0A, ASCII_ZERO = 8'h30, ASCII_A = 8'h41
  - function nibble_to_ascii
  - UART frame constants: START_BIT = 0, STOP_BIT = 1, DATA_BITS = 8
- One sub-module, uart_tx_byte:
  - Parameter CLKS_PER_BIT; ports clk, rst_n, byte_in[7:0], byte_valid, byte_ready, tx.
  - States IDLE, START, DATA, STOP.
  - Bit-period counter and 3-bit bit index.
- The report FSM, snapshot register and character mux stay in number_uart_reporter.

Test Plan:
- number = 16'h12AF, pulse send -> usb_tx decodes to 0x31 0x32 0x41 0x46 0x0D 0x0A; each bit is 100 clocks ±1; busy is high throughout; done fires once; busy falls with done.
- number = 16'h0000, then 16'hFFFF -> "0000\r\n" and "FFFF\r\n"; the start bit falls exactly 2 cycles after the send edge.
- Pulse send again at cycle 500 of a report, and change number to 16'h9999 mid-report -> only the original report is sent, with its original value; no second report.
- Pull rst_n low during the 3rd character's data bits -> usb_tx = 1 and busy = 0 at once, no done; a later send with number = 16'h0042 yields a clean "0042\r\n".
- BAUD_RATE = 115200 -> CLKS_PER_BIT = 868; each bit is 868 clocks; characters are separated by ≤2 idle clocks.
- Hold send high for 3 cycles while idle -> exactly one report.
